// File: rtl/branch_prediction_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_prediction_unit_pkg
// Brief    : Shared next-PC select codes, BTB entry layout and counter helpers.
// Revision : 1.0
// ============================================================================
package branch_prediction_unit_pkg;

  localparam logic [1:0] PC_SRC_SEQ_F    = 2'b00;
  localparam logic [1:0] PC_SRC_PRED_F   = 2'b01;
  localparam logic [1:0] PC_SRC_SEQ_E    = 2'b10;
  localparam logic [1:0] PC_SRC_TARGET_E = 2'b11;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is held right-aligned in a fixed 30-bit field so the layout is
  // independent of the table depth.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_prediction_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_prediction_unit_if
// Brief    : Fetch/execute-side signal bundle between the core and the BPU.
// Revision : 1.0
// ============================================================================
interface branch_prediction_unit_if;
  import branch_prediction_unit_pkg::*;

  logic [31:0] pc_f_i;
  logic        stall_d_i;
  logic        flush_d_i;
  logic        flush_e_i;
  logic [31:0] pc_e_i;
  logic        is_branch_e_i;
  logic        is_jump_e_i;
  logic        branch_taken_e_i;
  logic [31:0] pc_target_e_i;
  logic [1:0]  pc_src_o;
  logic [31:0] pred_pc_target_f_o;
  logic        mispredict_e_o;

  modport master (
    output pc_f_i, stall_d_i, flush_d_i, flush_e_i, pc_e_i,
           is_branch_e_i, is_jump_e_i, branch_taken_e_i, pc_target_e_i,
    input  pc_src_o, pred_pc_target_f_o, mispredict_e_o
  );

  modport slave (
    input  pc_f_i, stall_d_i, flush_d_i, flush_e_i, pc_e_i,
           is_branch_e_i, is_jump_e_i, branch_taken_e_i, pc_target_e_i,
    output pc_src_o, pred_pc_target_f_o, mispredict_e_o
  );

endinterface
`default_nettype wire

// File: rtl/branch_prediction_unit_btb_table.sv
`default_nettype none
// ============================================================================
// Module   : btb_table
// Brief    : BTB storage with one combinational lookup port and one training write port.
// Revision : 1.0
// ============================================================================
module btb_table
  import branch_prediction_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [29:0]      wr_tag,
  input  logic             wr_jump,
  input  logic             wr_taken,
  input  logic [31:0]      wr_target
);

  localparam btb_entry_t c_reset_entry = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  btb_entry_t r_mem [ENTRIES];
  btb_entry_t w_cur;
  btb_entry_t w_new;
  logic       w_hit;
  logic       w_write;

  assign rd_entry = r_mem[rd_idx];
  assign w_cur    = r_mem[wr_idx];
  assign w_hit    = w_cur.valid && (w_cur.tag == wr_tag);

  // Read-modify-write of the trained entry; jumps always (re)allocate strongly taken.
  always_comb begin
    w_new   = w_cur;
    w_write = 1'b0;
    if (wr_en) begin
      if (wr_jump) begin
        w_write = 1'b1;
        w_new   = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: CTR_ST};
      end else if (w_hit) begin
        w_write   = 1'b1;
        w_new.ctr = ctr_update(w_cur.ctr, wr_taken);
        if (wr_taken) w_new.target = wr_target;
      end else if (wr_taken) begin
        w_write = 1'b1;
        w_new   = '{valid: 1'b1, tag: wr_tag, target: wr_target, ctr: CTR_WT};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= c_reset_entry;
    end else if (w_write) begin
      r_mem[wr_idx] <= w_new;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_prediction_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_prediction_unit
// Brief    : BTB lookup in F, prediction pipeline to E, mispredict redirect and training.
// Revision : 1.0
// ============================================================================
module branch_prediction_unit
  import branch_prediction_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  branch_prediction_unit_if.slave  bus
);

  logic [IDX_W-1:0] w_idx_f;
  logic [29:0]      w_tag_f;
  btb_entry_t       w_entry_f;
  logic             w_hit_f;
  logic             w_pred_taken_f;
  logic [31:0]      w_pred_target_f;

  logic             r_pred_taken_d;
  logic [31:0]      r_pred_target_d;
  logic             r_pred_taken_e;
  logic [31:0]      r_pred_target_e;

  logic             w_ctl_e;
  logic             w_taken_e;
  logic             w_mispredict_e;
  logic [1:0]       w_src_e;

  assign w_idx_f         = bus.pc_f_i[IDX_W+1:2];
  assign w_tag_f         = 30'(bus.pc_f_i[31:IDX_W+2]);
  assign w_hit_f         = w_entry_f.valid && (w_entry_f.tag == w_tag_f);
  assign w_pred_taken_f  = w_hit_f && w_entry_f.ctr[1];
  assign w_pred_target_f = w_hit_f ? w_entry_f.target : 32'd0;

  btb_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btb_table (
    .clk       (clk_i),
    .rst       (reset_i),
    .rd_idx    (w_idx_f),
    .rd_entry  (w_entry_f),
    .wr_en     (w_ctl_e),
    .wr_idx    (bus.pc_e_i[IDX_W+1:2]),
    .wr_tag    (30'(bus.pc_e_i[31:IDX_W+2])),
    .wr_jump   (bus.is_jump_e_i),
    .wr_taken  (bus.branch_taken_e_i),
    .wr_target (bus.pc_target_e_i)
  );

  // Flush beats stall in D; E follows D unconditionally unless flushed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= 32'd0;
      r_pred_taken_e  <= 1'b0;
      r_pred_target_e <= 32'd0;
    end else begin
      if (bus.flush_d_i) begin
        r_pred_taken_d  <= 1'b0;
        r_pred_target_d <= 32'd0;
      end else if (!bus.stall_d_i) begin
        r_pred_taken_d  <= w_pred_taken_f;
        r_pred_target_d <= w_pred_target_f;
      end
      if (bus.flush_e_i) begin
        r_pred_taken_e  <= 1'b0;
        r_pred_target_e <= 32'd0;
      end else begin
        r_pred_taken_e  <= r_pred_taken_d;
        r_pred_target_e <= r_pred_target_d;
      end
    end
  end

  assign w_ctl_e   = bus.is_branch_e_i | bus.is_jump_e_i;
  assign w_taken_e = w_ctl_e & bus.branch_taken_e_i;

  always_comb begin
    w_mispredict_e = 1'b0;
    w_src_e        = PC_SRC_SEQ_E;
    if (r_pred_taken_e && !w_taken_e) begin
      w_mispredict_e = 1'b1;
      w_src_e        = PC_SRC_SEQ_E;
    end else if (w_taken_e && (!r_pred_taken_e || (r_pred_target_e != bus.pc_target_e_i))) begin
      w_mispredict_e = 1'b1;
      w_src_e        = PC_SRC_TARGET_E;
    end
  end

  assign bus.mispredict_e_o     = w_mispredict_e;
  assign bus.pred_pc_target_f_o = w_pred_target_f;
  assign bus.pc_src_o           = w_mispredict_e ? w_src_e :
                                  w_pred_taken_f ? PC_SRC_PRED_F : PC_SRC_SEQ_F;

endmodule
`default_nettype wire

// File: doc/branch_prediction_unit.md
# branch_prediction_unit

Branch target buffer (BTB) and resolution logic that drives the fetch stage's next-PC selection. It looks up the fetch PC every cycle and supplies the predicted target and `pc_src_o`. It carries each prediction through decode to execute, compares it with the resolved outcome, and redirects fetch on a mispredict. It also trains its 2-bit saturating counters and stored targets from resolved control-flow instructions in execute.

## Interface
Parameters:
- `ENTRIES`, default 64: number of BTB entries; must be a power of two, at least 4.
- `IDX_W`, default `$clog2(ENTRIES)`: index width; derived, never overridden.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset. One clock; reset is asynchronous and active-high.
- `pc_f_i`  in  32  current fetch PC.
- `stall_d_i`  in  1  hold the D-stage prediction register.
- `flush_d_i`  in  1  clear the D-stage prediction register.
- `flush_e_i`  in  1  clear the E-stage prediction register.
- `pc_e_i`  in  32  PC of the instruction in E.
- `is_branch_e_i`  in  1  conditional branch in E.
- `is_jump_e_i`  in  1  jal/jalr in E.
- `branch_taken_e_i`  in  1  resolved outcome; the core drives it to 1 for jumps.
- `pc_target_e_i`  in  32  resolved target in E.
- `pc_src_o`  out  2  next-PC select, using the `PC_SRC_*` encoding.
- `pred_pc_target_f_o`  out  32  predicted target for `pc_f_i`.
- `mispredict_e_o`  out  1  redirect request to the hazard unit, which flushes D and E.

## Operation
Entry contents:
- `valid`, 1 bit.
- `tag = pc[31:IDX_W+2]`.
- `target`, 32 bits.
- `ctr`, 2 bits.
- Index is `pc[IDX_W+1:2]`.

F lookup (combinational):
- `hit_f = valid && tag match`.
- `pred_taken_f = hit_f && ctr[1]`.
- `pred_pc_target_f_o` is the entry target on hit, 0 on miss.

Prediction pipeline:
- Registers `{pred_taken, pred_target}` advance F→D→E.
- D register: `flush_d_i` clears it to 0 and has priority over `stall_d_i`; `stall_d_i` holds it.
- E register: loads from D every cycle; `flush_e_i` clears it to 0.

E resolution, with `ctl_e = is_branch_e_i | is_jump_e_i`:
- Predicted taken, but not (`ctl_e` and actually taken) → mispredict, select `PC_SRC_SEQ_E`.
- `ctl_e`, taken, and predicted not taken → mispredict, select `PC_SRC_TARGET_E`.
- `ctl_e`, taken, predicted taken, and `pred_target != pc_target_e_i` → mispredict, select `PC_SRC_TARGET_E`.

`pc_src_o` priority:
- An E mispredict selects as listed above.
- Otherwise `pred_taken_f` selects `PC_SRC_PRED_F`.
- Otherwise `PC_SRC_SEQ_F`.

Training occurs at the clock edge when `ctl_e` is high:
- Conditional hit: `ctr` saturating ±1 (00..11). When taken, `target ← pc_target_e_i`.
- Conditional miss, taken: allocate with `valid=1`, tag, target, `ctr=2'b10`.
- Conditional miss, not taken: no allocation.
- Jump: allocate or overwrite with `ctr=2'b11` and target.
- Index collision: the new tag replaces the old entry.

## Timing
- Lookup, mispredict detection and `pc_src_o` are combinational. The redirect takes effect at the next edge.
- Mispredict penalty: 2 cycles, covering the D and E flushes.
- Table write is visible one cycle after the edge. A same-cycle lookup of the index being trained sees the old contents; there is no bypass.
- A simultaneous F prediction and E mispredict resolves to the E mispredict.
- Reset values:
  - All table entries: `valid=0`, `ctr=2'b01`, `target=0`, `tag=0`.
  - Pipeline registers: 0.
  - Outputs: `pc_src_o=PC_SRC_SEQ_F`, `pred_pc_target_f_o=0`, `mispredict_e_o=0`.
- Reset asserted mid-operation clears all state immediately and asynchronously. No training write occurs on that edge.

## Structure
- `PC_SRC_SEQ_F=2'b00`, `PC_SRC_PRED_F=2'b01`, `PC_SRC_SEQ_E=2'b10` and `PC_SRC_TARGET_E=2'b11` live in the shared control definitions.
- The BTB entry struct and the counter constants (`CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`) go in a shared package.
- One sub-module: `btb_table`, holding the storage, the combinational read port and the single synchronous write port.

## Test plan
- Reset, then `pc_f_i=0x100` → `pc_src_o=00`, `pred_pc_target_f_o=0`, `mispredict_e_o=0`.
- Taken branch at 0x100 to 0x200, first encounter → `mispredict_e_o=1`, `pc_src_o=11`. Next lookup of 0x100 → hit, `ctr=10`, `pc_src_o=01`, target 0x200.
- Predicted-taken 0x100 resolves not taken → `pc_src_o=10`. Entry `ctr` goes 10→01, and the next lookup selects `00`.
- Jump at 0x300 with a stored target of 0x400 resolves to 0x500 → mispredict, `pc_src_o=11`, and the entry target updates to 0x500.
- Prediction in D, then `flush_d_i=1` → E register holds 0, so no spurious `SEQ_E` redirect. With `stall_d_i=1` and `flush_d_i=0`, the D prediction is held.
- Training in flight, then `reset_i` asserted between edges → all entries invalid immediately and `pc_src_o=00`.
